// File: rtl/bitunpacker_if.sv
// bitunpacker_if: word-in / peek / consume bundle for the bit unpacker.
//   word_in_valid/word_in/word_in_ready : word stream from the source
//   bits_out/bits_available             : peek window and fill level
//   consume_valid/consume_length        : drop request from the decoder
//   underflow                           : sticky illegal-consume flag
//   align (BITUNPACKER_ALIGN_EN only)   : skip to the next 32-bit boundary
// slave = the unpacker, master = the source/consumer side.
interface bitunpacker_if;
  logic        word_in_valid;
  logic [31:0] word_in;
  logic        word_in_ready;
  logic [31:0] bits_out;
  logic [6:0]  bits_available;
  logic        consume_valid;
  logic [5:0]  consume_length;
  logic        underflow;
`ifdef BITUNPACKER_ALIGN_EN
  logic        align;

  modport slave  (input  word_in_valid, word_in, consume_valid, consume_length, align,
                  output word_in_ready, bits_out, bits_available, underflow);
  modport master (output word_in_valid, word_in, consume_valid, consume_length, align,
                  input  word_in_ready, bits_out, bits_available, underflow);
`else
  modport slave  (input  word_in_valid, word_in, consume_valid, consume_length,
                  output word_in_ready, bits_out, bits_available, underflow);
  modport master (output word_in_valid, word_in, consume_valid, consume_length,
                  input  word_in_ready, bits_out, bits_available, underflow);
`endif
endinterface

// File: rtl/bitunpacker.sv
// bitunpacker: 64-bit LSB-first bit buffer fed by 32-bit words; the consumer
// peeks at the low 32 bits and drops 0..32 bits per cycle.
// Ports:
//   clk    : rising-edge clock
//   rst    : asynchronous active-high reset
//   io_bus : bitunpacker_if.slave (word in, peek window, consume, underflow)
// Optional feature macro: BITUNPACKER_ALIGN_EN adds the align input and a
// phase register tracking bits consumed mod 32.
module bitunpacker (
  input  logic            clk,
  input  logic            rst,
  bitunpacker_if.slave    io_bus
);
  logic [63:0] r_buf;
  logic [6:0]  r_count;
  logic        r_underflow;

  logic        w_ready;
  logic        w_accept;
  logic [6:0]  w_len;      // bits dropped this edge (0 when nothing legal)
  logic        w_illegal;
  logic [6:0]  w_shamt;
  logic [63:0] w_ins;
  logic [63:0] w_buf_nxt;
  logic [6:0]  w_cnt_nxt;

`ifdef BITUNPACKER_ALIGN_EN
  logic [4:0]  r_phase;
  logic [4:0]  w_d;
`endif

  // Ready depends only on the registered count, never on this cycle's consume.
  assign w_ready  = (r_count <= 7'd32);
  assign w_accept = io_bus.word_in_valid && w_ready;

  always_comb begin
    w_len     = 7'd0;
    w_illegal = 1'b0;
`ifdef BITUNPACKER_ALIGN_EN
    // Distance to the next word boundary of the consumed stream.
    w_d = 5'd0 - r_phase;
    if (io_bus.align) begin
      if ({2'b00, w_d} <= r_count) w_len = {2'b00, w_d};
      else                         w_illegal = 1'b1;
    end else
`endif
    if (io_bus.consume_valid) begin
      if ((io_bus.consume_length <= 6'd32) && ({1'b0, io_bus.consume_length} <= r_count))
        w_len = {1'b0, io_bus.consume_length};
      else
        w_illegal = 1'b1;
    end
    // New word lands right above the bits that survive this edge's shift;
    // accept implies count <= 32 so the shift never exceeds 32.
    w_shamt   = r_count - w_len;
    w_ins     = w_accept ? ({32'd0, io_bus.word_in} << w_shamt) : 64'd0;
    w_buf_nxt = (r_buf >> w_len) | w_ins;
    w_cnt_nxt = r_count - w_len + (w_accept ? 7'd32 : 7'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf       <= 64'd0;
      r_count     <= 7'd0;
      r_underflow <= 1'b0;
    end else begin
      r_buf   <= w_buf_nxt;
      r_count <= w_cnt_nxt;
      if (w_illegal) r_underflow <= 1'b1;
    end
  end

`ifdef BITUNPACKER_ALIGN_EN
  // A legal align adds exactly D, which wraps phase back to 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_phase <= 5'd0;
    else     r_phase <= r_phase + w_len[4:0];
  end
`endif

  assign io_bus.bits_out       = r_buf[31:0];
  assign io_bus.bits_available = r_count;
  assign io_bus.word_in_ready  = w_ready;
  assign io_bus.underflow      = r_underflow;
endmodule

// File: tb/tb_bitunpacker.sv
module tb_bitunpacker;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bitunpacker_if bus ();
  bitunpacker dut (.clk(clk), .rst(rst), .io_bus(bus));

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic        wv;
    logic [31:0] w;
    logic        cv;
    logic [5:0]  cl;
    logic [6:0]  ea;
    logic [31:0] eo;
    logic        er;
    logic        eu;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [6:0] ea, input logic [31:0] eo,
                         input logic er, input logic eu);
    chk({tag, " avail"}, {25'd0, bus.bits_available}, {25'd0, ea});
    chk({tag, " out"},   bus.bits_out, eo);
    chk({tag, " ready"}, {31'd0, bus.word_in_ready}, {31'd0, er});
    chk({tag, " uflow"}, {31'd0, bus.underflow}, {31'd0, eu});
  endtask

  task automatic idle();
    bus.word_in_valid  = 1'b0;
    bus.word_in        = 32'd0;
    bus.consume_valid  = 1'b0;
    bus.consume_length = 6'd0;
`ifdef BITUNPACKER_ALIGN_EN
    bus.align          = 1'b0;
`endif
  endtask

  // Drive at negedge, let one rising edge happen, sample 1 time unit later.
  task automatic cyc(input logic wv, input logic [31:0] w, input logic cv, input logic [5:0] cl);
    @(negedge clk);
    bus.word_in_valid  = wv;
    bus.word_in        = w;
    bus.consume_valid  = cv;
    bus.consume_length = cl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //          wv  word          cv  len    avail  out           rdy  uf
    tbl[0]  = '{1, 32'hDEADBEEF,  0, 6'd0,  7'd32, 32'hDEADBEEF, 1, 0};
    tbl[1]  = '{0, 32'h0,         1, 6'd4,  7'd28, 32'h0DEADBEE, 1, 0};
    tbl[2]  = '{1, 32'h12345678,  1, 6'd12, 7'd48, 32'h5678DEAD, 0, 0};
    tbl[3]  = '{0, 32'h0,         1, 6'd16, 7'd32, 32'h12345678, 1, 0};
    tbl[4]  = '{0, 32'h0,         1, 6'd32, 7'd0,  32'h00000000, 1, 0};
    tbl[5]  = '{1, 32'hAAAA5555,  0, 6'd0,  7'd32, 32'hAAAA5555, 1, 0};
    tbl[6]  = '{1, 32'h0F0F1234,  0, 6'd0,  7'd64, 32'hAAAA5555, 0, 0};
    tbl[7]  = '{1, 32'hFFFFFFFF,  1, 6'd31, 7'd33, 32'h1E1E2469, 0, 0};
    tbl[8]  = '{1, 32'hFFFFFFFF,  1, 6'd1,  7'd32, 32'h0F0F1234, 1, 0};
    tbl[9]  = '{0, 32'h0,         1, 6'd16, 7'd16, 32'h00000F0F, 1, 0};
    tbl[10] = '{0, 32'h0,         1, 6'd20, 7'd16, 32'h00000F0F, 1, 1};
    tbl[11] = '{1, 32'h11112222,  0, 6'd0,  7'd48, 32'h22220F0F, 0, 1};
    tbl[12] = '{0, 32'h0,         1, 6'd33, 7'd48, 32'h22220F0F, 0, 1};
    tbl[13] = '{0, 32'h0,         1, 6'd0,  7'd48, 32'h22220F0F, 0, 1};
    tbl[14] = '{0, 32'h0,         0, 6'd8,  7'd48, 32'h22220F0F, 0, 1};

    idle();
    #1;
    chk_all("reset", 7'd0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      cyc(tbl[i].wv, tbl[i].w, tbl[i].cv, tbl[i].cl);
      chk_all($sformatf("vec%0d", i), tbl[i].ea, tbl[i].eo, tbl[i].er, tbl[i].eu);
    end

    // Asynchronous reset mid-cycle with 48 bits buffered and underflow set.
    @(negedge clk);
    idle();
    #2;
    rst = 1'b1;
    #1;
    chk_all("async_rst", 7'd0, 32'h0, 1'b1, 1'b0);

    // Word presented on the first edge after reset release is taken.
    @(negedge clk);
    rst = 1'b0;
    bus.word_in_valid = 1'b1;
    bus.word_in       = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    chk_all("post_rst_accept", 7'd32, 32'hCAFEF00D, 1'b1, 1'b0);

    // Empty buffer: consume 1 is illegal, consume 0 is fine, accept still works.
    @(negedge clk);
    rst = 1'b1;
    idle();
    @(negedge clk);
    rst = 1'b0;
    cyc(1'b0, 32'h0, 1'b1, 6'd0);
    chk_all("empty_c0", 7'd0, 32'h0, 1'b1, 1'b0);
    cyc(1'b1, 32'h00C0FFEE, 1'b1, 6'd1);
    chk_all("empty_c1", 7'd32, 32'h00C0FFEE, 1'b1, 1'b1);

`ifdef BITUNPACKER_ALIGN_EN
    @(negedge clk);
    rst = 1'b1;
    idle();
    @(negedge clk);
    rst = 1'b0;
    cyc(1'b1, 32'hDEADBEEF, 1'b0, 6'd0);
    cyc(1'b0, 32'h0, 1'b1, 6'd4);
    chk_all("al_pre", 7'd28, 32'h0DEADBEE, 1'b1, 1'b0);
    // Align wins over a simultaneous (even illegal) consume.
    @(negedge clk);
    bus.align          = 1'b1;
    bus.consume_valid  = 1'b1;
    bus.consume_length = 6'd40;
    @(posedge clk);
    #1;
    chk_all("align", 7'd0, 32'h0, 1'b1, 1'b0);
    // Phase is now 0: a second align drops nothing.
    @(negedge clk);
    bus.align          = 1'b1;
    bus.consume_valid  = 1'b0;
    bus.word_in_valid  = 1'b1;
    bus.word_in        = 32'h87654321;
    @(posedge clk);
    #1;
    chk_all("align2", 7'd32, 32'h87654321, 1'b1, 1'b0);
    @(negedge clk);
    idle();
`endif

    @(negedge clk);
    idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
